fc_func: RTL and testbench

- Downstream stage of the FC layer controller. On a single-cycle start pulse it drains the layer's output buffer (OBUF) one element per cycle.
- Applies ReLU, right-shift requantisation and unsigned saturation to each element, then packs the results into BUS_WIDTH words and writes them into the next layer's input buffer (IBUF).
- Once all words are written, it starts the next layer's controller with a level handshake.
- It provides the func-ready/func-start handshake that the FC controller waits on.

---
 rtl/fc_func.sv | 175 +++++++++++++++++
 tb/tb_fc_func.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_func.sv
// ============================================================================
// Module   : fc_func
// Purpose  : FC-layer output stage. Drains the OBUF one element per cycle,
//            applies ReLU, right-shift requantisation and unsigned saturation,
//            packs the activations into BUS_WIDTH words for the next layer's
//            IBUF, then starts the next layer with a level handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_func #(
    parameter int DATA_SIZE      = 8,
    parameter int XBAR_SIZE      = 256,
    parameter int OBUF_DATA_SIZE = 2*DATA_SIZE + $clog2(XBAR_SIZE),
    parameter int BUS_WIDTH      = 16,
    parameter int NUM_OUTPUTS    = 32,
    parameter int SHIFT          = 4,
    localparam int EPW           = BUS_WIDTH / DATA_SIZE,
    localparam int NUM_WORDS     = (NUM_OUTPUTS + EPW - 1) / EPW,
    localparam int OBUF_AW       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    localparam int IBUF_AW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int LANE_W        = (EPW > 1) ? $clog2(EPW) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_ready,
    output logic                      o_obuf_re,
    output logic [OBUF_AW-1:0]        o_obuf_addr,
    input  logic [OBUF_DATA_SIZE-1:0] i_obuf_data,
    output logic                      o_ibuf_we,
    output logic [IBUF_AW-1:0]        o_ibuf_addr,
    output logic [BUS_WIDTH-1:0]      o_ibuf_data,
    input  logic                      i_next_ready,
    output logic                      o_next_start
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_START = 3'd4;

    localparam logic [DATA_SIZE-1:0] C_SAT_MAX = {DATA_SIZE{1'b1}};

    logic [2:0]           state_q,    state_d;
    logic [OBUF_AW-1:0]   rd_cnt_q,   rd_cnt_d;
    logic                 vld_q,      vld_d;
    logic                 vld_last_q, vld_last_d;
    logic [LANE_W-1:0]    lane_q,     lane_d;
    logic [IBUF_AW-1:0]   word_q,     word_d;
    logic [BUS_WIDTH-1:0] pack_q,     pack_d;
    logic                 ibuf_we_q,  ibuf_we_d;
    logic [IBUF_AW-1:0]   ibuf_addr_q, ibuf_addr_d;
    logic [BUS_WIDTH-1:0] ibuf_data_q, ibuf_data_d;

    logic                             w_last_rd;
    logic                             w_final_wr;
    logic                             w_lane_end;
    logic signed [OBUF_DATA_SIZE-1:0] w_x;
    logic signed [OBUF_DATA_SIZE-1:0] w_y;
    logic [DATA_SIZE-1:0]             w_r;
    logic [BUS_WIDTH-1:0]             w_pack_next;

    assign w_last_rd  = (rd_cnt_q == OBUF_AW'(NUM_OUTPUTS - 1));
    // The last word's write is the only write with the top address in a pass.
    assign w_final_wr = ibuf_we_q && (ibuf_addr_q == IBUF_AW'(NUM_WORDS - 1));
    // A word closes on its top lane, or early on the last element of the pass.
    assign w_lane_end = vld_last_q || (lane_q == LANE_W'(EPW - 1));

    // State and datapath registers with synchronous reset (aborts any pass).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_cnt_q    <= '0;
            vld_q       <= 1'b0;
            vld_last_q  <= 1'b0;
            lane_q      <= '0;
            word_q      <= '0;
            pack_q      <= '0;
            ibuf_we_q   <= 1'b0;
            ibuf_addr_q <= '0;
            ibuf_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            vld_q       <= vld_d;
            vld_last_q  <= vld_last_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            pack_q      <= pack_d;
            ibuf_we_q   <= ibuf_we_d;
            ibuf_addr_q <= ibuf_addr_d;
            ibuf_data_q <= ibuf_data_d;
        end
    end

    // Next-state logic: wait for a free next layer, read, drain, hand off.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start)       state_d = S_WAIT;
            S_WAIT:  if (i_next_ready)  state_d = S_READ;
            S_READ:  if (w_last_rd)     state_d = S_DRAIN;
            S_DRAIN: if (w_final_wr)    state_d = S_START;
            S_START: if (!i_next_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the state.
    always_comb begin
        o_ready      = (state_q == S_IDLE);
        o_obuf_re    = (state_q == S_READ);
        o_next_start = (state_q == S_START);
    end

    assign o_obuf_addr = rd_cnt_q;
    assign o_ibuf_we   = ibuf_we_q;
    assign o_ibuf_addr = ibuf_addr_q;
    assign o_ibuf_data = ibuf_data_q;

    // ReLU + floor shift + saturation; negatives clamp to zero before shifting.
    always_comb begin
        w_x = $signed(i_obuf_data);
        w_y = w_x >>> SHIFT;
        if (w_x[OBUF_DATA_SIZE-1]) begin
            w_r = '0;
        end else if (|w_y[OBUF_DATA_SIZE-1:DATA_SIZE]) begin
            w_r = C_SAT_MAX;
        end else begin
            w_r = w_y[DATA_SIZE-1:0];
        end
        w_pack_next = pack_q;
        w_pack_next[int'(lane_q)*DATA_SIZE +: DATA_SIZE] = w_r;
    end

    // Read address sequencing, element pipeline, lane packing and word writes.
    always_comb begin
        rd_cnt_d    = rd_cnt_q;
        vld_d       = (state_q == S_READ);
        vld_last_d  = (state_q == S_READ) && w_last_rd;
        lane_d      = lane_q;
        word_d      = word_q;
        pack_d      = pack_q;
        ibuf_we_d   = 1'b0;
        ibuf_addr_d = ibuf_addr_q;
        ibuf_data_d = ibuf_data_q;

        if (state_q == S_READ) begin
            rd_cnt_d = w_last_rd ? '0 : rd_cnt_q + 1'b1;
        end

        if (state_q == S_IDLE) begin
            word_d = '0;
        end

        if (vld_q) begin
            if (w_lane_end) begin
                ibuf_we_d   = 1'b1;
                ibuf_addr_d = word_q;
                ibuf_data_d = w_pack_next;
                pack_d      = '0;
                lane_d      = '0;
                word_d      = word_q + 1'b1;
            end else begin
                pack_d = w_pack_next;
                lane_d = lane_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_func.sv
// ============================================================================
// Module   : tb_fc_func
// Purpose  : Self-checking bench for fc_func (5 outputs, 8-bit data, 16-bit
//            bus, shift 4). Table vectors, handshake/reset sequences and
//            random passes checked against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_func;

    localparam int NO = 5;
    localparam int NW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        o_ready;
    logic        o_obuf_re;
    logic [2:0]  o_obuf_addr;
    logic [23:0] i_obuf_data = '0;
    logic        o_ibuf_we;
    logic [1:0]  o_ibuf_addr;
    logic [15:0] o_ibuf_data;
    logic        i_next_ready;
    logic        o_next_start;

    fc_func #(
        .DATA_SIZE   (8),
        .XBAR_SIZE   (256),
        .BUS_WIDTH   (16),
        .NUM_OUTPUTS (NO),
        .SHIFT       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .o_ready      (o_ready),
        .o_obuf_re    (o_obuf_re),
        .o_obuf_addr  (o_obuf_addr),
        .i_obuf_data  (i_obuf_data),
        .o_ibuf_we    (o_ibuf_we),
        .o_ibuf_addr  (o_ibuf_addr),
        .o_ibuf_data  (o_ibuf_data),
        .i_next_ready (i_next_ready),
        .o_next_start (o_next_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NO-1:0][23:0] obuf;
        logic [NW-1:0][15:0] words;
        logic [3:0]          hold;
    } vec_t;

    typedef struct {
        int          cyc;
        int          addr;
        logic [15:0] data;
    } wr_t;

    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    logic [23:0] obuf_mem [NO];
    wr_t  wrq[$];
    int   rd_cyc[$];
    int   rd_addr[$];
    int   start_rise[$];
    logic prev_start = 1'b0;

    // OBUF model: one-cycle read latency
    always @(posedge clk) begin
        if (o_obuf_re) i_obuf_data <= obuf_mem[o_obuf_addr];
    end

    always @(posedge clk) cyc++;

    // Transaction monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (o_ibuf_we) wrq.push_back('{cyc, int'(o_ibuf_addr), o_ibuf_data});
        if (o_obuf_re) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(o_obuf_addr));
        end
        if (o_next_start && !prev_start) start_rise.push_back(cyc);
        prev_start = o_next_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: ReLU, floor divide by 2^4, clamp to 255, two lanes per word
    function automatic int requant(input logic [23:0] raw);
        int x;
        int y;
        x = int'($signed(raw));
        if (x < 0) return 0;
        y = x / 16;
        return (y > 255) ? 255 : y;
    endfunction

    function automatic logic [NW-1:0][15:0] model_words(input logic [NO-1:0][23:0] ob);
        int acc [NW];
        logic [NW-1:0][15:0] res;
        for (int w = 0; w < NW; w++) acc[w] = 0;
        for (int k = 0; k < NO; k++) acc[k/2] += requant(ob[k]) * ((k % 2 == 1) ? 256 : 1);
        for (int w = 0; w < NW; w++) res[w] = 16'(acc[w]);
        return res;
    endfunction

    task automatic clear_mon();
        wrq.delete();
        rd_cyc.delete();
        rd_addr.delete();
        start_rise.delete();
    endtask

    task automatic load(input logic [NO-1:0][23:0] ob);
        for (int k = 0; k < NO; k++) obuf_mem[k] = ob[k];
    endtask

    task automatic start_pass(input logic rdy);
        @(negedge clk);
        i_next_ready = rdy;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Wait for o_next_start, run the handshake, then audit the whole pass
    task automatic finish_pass(input string tag, input logic [NW-1:0][15:0] exp, input int hold);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (o_next_start) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            check({tag, "_start_timeout"}, 0, 1);
            i_next_ready = 1'b0;
            repeat (3) @(negedge clk);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            check({tag, "_start_held"}, o_next_start, 1);
            @(negedge clk);
        end
        i_next_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ready_back"}, {o_ready, o_next_start}, 2'b10);

        check({tag, "_nwrites"}, wrq.size(), NW);
        if (wrq.size() == NW) begin
            for (int w = 0; w < NW; w++) begin
                check({tag, "_waddr"}, wrq[w].addr, w);
                check({tag, "_wdata"}, wrq[w].data, exp[w]);
            end
        end
        check({tag, "_nreads"}, rd_cyc.size(), NO);
        if (rd_cyc.size() == NO) begin
            for (int k = 0; k < NO; k++) begin
                check({tag, "_raddr"}, rd_addr[k], k);
                check({tag, "_rcyc"}, rd_cyc[k] - rd_cyc[0], k);
            end
            if (wrq.size() == NW) check({tag, "_lastwr_lat"}, wrq[NW-1].cyc - rd_cyc[NO-1], 2);
        end
        check({tag, "_nstarts"}, start_rise.size(), 1);
        if (start_rise.size() == 1 && wrq.size() == NW)
            check({tag, "_start_lat"}, start_rise[0] - wrq[NW-1].cyc, 1);
    endtask

    task automatic do_pass(input string tag, input logic [NO-1:0][23:0] ob,
                           input logic [NW-1:0][15:0] exp, input int hold);
        load(ob);
        clear_mon();
        start_pass(1'b1);
        finish_pass(tag, exp, hold);
    endtask

    vec_t tbl [4];

    initial begin
        logic [NO-1:0][23:0] ob;
        bit ok;

        tbl[0] = '{obuf: {24'd17, 24'd8000, 24'd4095, 24'd291, 24'hFFFF9C},
                   words: {16'h0001, 16'hFFFF, 16'h1200}, hold: 4'd4};
        tbl[1] = '{obuf: {NO{24'h000000}},
                   words: {16'h0000, 16'h0000, 16'h0000}, hold: 4'd1};
        tbl[2] = '{obuf: {NO{24'h7FFFFF}},
                   words: {16'h00FF, 16'hFFFF, 16'hFFFF}, hold: 4'd2};
        tbl[3] = '{obuf: {24'h800000, 24'd4096, 24'd15, 24'd16, 24'hFFFFFF},
                   words: {16'h0000, 16'hFF00, 16'h0100}, hold: 4'd1};

        rst = 1'b1;
        i_start = 1'b0;
        i_next_ready = 1'b0;
        for (int k = 0; k < NO; k++) obuf_mem[k] = '0;
        repeat (3) @(negedge clk);
        check("reset_ready",   o_ready, 1);
        check("reset_outs",    {o_obuf_re, o_ibuf_we, o_next_start}, 3'b000);
        check("reset_addrs",   {o_obuf_addr, o_ibuf_addr}, 5'd0);
        check("reset_data",    o_ibuf_data, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven passes
        for (int i = 0; i < 4; i++) do_pass($sformatf("vec%0d", i), tbl[i].obuf, tbl[i].words, int'(tbl[i].hold));

        // Next layer busy: nothing happens until it is ready
        load(tbl[0].obuf);
        clear_mon();
        start_pass(1'b0);
        for (int i = 0; i < 10; i++) begin
            check("busy_idle", {o_obuf_re, o_ready}, 2'b00);
            @(negedge clk);
        end
        i_next_ready = 1'b1;
        @(negedge clk);
        check("busy_first_read", {o_obuf_re, o_obuf_addr}, 4'b1_000);
        finish_pass("busy", tbl[0].words, 2);

        // Start pulse during READ is ignored
        load(tbl[0].obuf);
        clear_mon();
        start_pass(1'b1);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (o_obuf_re) ok = 1;
            else @(negedge clk);
        end
        check("ign_read_seen", ok, 1);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        finish_pass("ign", tbl[0].words, 1);
        repeat (6) @(negedge clk);
        check("ign_no_second_pass", {rd_cyc.size(), o_ready}, {32'(NO), 1'b1});

        // Reset after the second read aborts the pass
        load(tbl[0].obuf);
        clear_mon();
        start_pass(1'b1);
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (o_obuf_re && o_obuf_addr == 3'd1) ok = 1;
            else @(negedge clk);
        end
        check("rst_second_read_seen", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("rst_idle", {o_ready, o_obuf_re, o_ibuf_we, o_next_start}, 4'b1000);
            @(negedge clk);
        end
        check("rst_no_writes", wrq.size(), 0);
        check("rst_no_start", start_rise.size(), 0);
        i_next_ready = 1'b0;
        @(negedge clk);
        do_pass("post_rst", tbl[0].obuf, tbl[0].words, 1);

        // Random passes against the reference model
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < NO; k++) begin
                case ($urandom_range(0, 3))
                    0: ob[k] = 24'($urandom) | 24'h800000;
                    1: ob[k] = 24'($urandom_range(0, 4095));
                    2: ob[k] = 24'($urandom_range(4096, 24'h7FFFFF));
                    default: ob[k] = 24'($urandom);
                endcase
            end
            do_pass($sformatf("rnd%0d", r), ob, model_words(ob), int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
